// File: rtl/pwm_pkg.sv
// Shared constants, mode encodings and ramp state type for the PWM duty sequencer.
// The timer and duty-ramp blocks take their parameter defaults from here.
package pwm_pkg;

    localparam int unsigned DUTY_W   = 6;
    localparam int unsigned PERIOD   = 32;
    localparam int unsigned DUTY_MAX = 32;
    localparam int unsigned STEP     = 1;

    // Divider reload reaches 7 at rate=3 (one step every 8 periods).
    localparam int unsigned DIV_W    = 3;

    localparam logic [1:0] MODE_DIRECT  = 2'b00;
    localparam logic [1:0] MODE_RAMP    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        BR_UP = 3'd3,
        BR_DN = 3'd4,
        HOLD  = 3'd5
    } ramp_state_t;

    // Periods between steps is 2^rate, so the divider reloads to 2^rate-1.
    function automatic logic [DIV_W-1:0] rate_reload(input logic [1:0] rate);
        logic [DIV_W-1:0] r;
        case (rate)
            2'd0:    r = 3'd0;
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

    function automatic logic state_moving(input ramp_state_t s);
        return (s == UP) || (s == DOWN) || (s == BR_UP) || (s == BR_DN);
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running period counter 0..PERIOD-1 with a one-cycle tick on the last count.
// Shared with the PWM stage so duty updates line up with its counter wrap.
module pwm_period_timer #(
    parameter int unsigned PERIOD = pwm_pkg::PERIOD
) (
    input  logic clk,
    input  logic rst,
    output logic period_tick
);

    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;

    always_comb begin
        pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_tick = (pcnt_q == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-word sequencer: direct, slewed ramp, triangle breathe or hold, updated
// only at PWM period boundaries so the PWM stage never sees a mid-period change.
module pwm_duty_ramp #(
    parameter int unsigned DUTY_W   = pwm_pkg::DUTY_W,
    parameter int unsigned PERIOD   = pwm_pkg::PERIOD,
    parameter int unsigned DUTY_MAX = pwm_pkg::DUTY_MAX,
    parameter int unsigned STEP     = pwm_pkg::STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target,
    input  logic [1:0]        mode,
    input  logic [1:0]        rate,
    output logic [DUTY_W-1:0] duty_o,
    output logic              period_tick,
    output logic              busy,
    output logic              at_target
);

    import pwm_pkg::*;

    // The ceiling can never exceed what the duty word can represent.
    localparam int unsigned WORD_MAX    = (1 << DUTY_W) - 1;
    localparam int unsigned TGT_CLAMP_I = (DUTY_MAX > WORD_MAX) ? WORD_MAX : DUTY_MAX;
    localparam logic [DUTY_W-1:0] TGT_CLAMP = DUTY_W'(TGT_CLAMP_I);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

    logic [DUTY_W-1:0] tgt_q,  tgt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [1:0]        mode_q, mode_d;
    logic [DIV_W-1:0]  div_q,  div_d;
    ramp_state_t       state_q, state_d;

    logic [DUTY_W-1:0] tgt_new;
    logic              step_ok;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_diff;
    logic              dn_under;
    logic [DUTY_W-1:0] up_lim;
    logic [DUTY_W-1:0] dn_lim;
    logic [DUTY_W-1:0] dn_floor;
    logic              br_go_up;

    pwm_period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .period_tick(period_tick)
    );

    // Step candidates, one bit wider so neither direction can wrap.
    always_comb begin
        tgt_new  = (target > TGT_CLAMP) ? TGT_CLAMP : target;
        step_ok  = (div_q == '0);
        up_sum   = {1'b0, duty_q} + STEP_X;
        dn_diff  = {1'b0, duty_q} - STEP_X;
        dn_under = ({1'b0, duty_q} < STEP_X);
        up_lim   = (up_sum > {1'b0, tgt_new}) ? tgt_new : up_sum[DUTY_W-1:0];
        dn_lim   = (dn_under || (dn_diff < {1'b0, tgt_new})) ? tgt_new : dn_diff[DUTY_W-1:0];
        dn_floor = dn_under ? '0 : dn_diff[DUTY_W-1:0];
        // Entering breathe picks its direction from where duty sits relative to target.
        br_go_up = (mode_q != MODE_BREATHE) ? (duty_q <= tgt_new) : (state_q == BR_UP);
    end

    always_comb begin
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        div_d   = div_q;
        duty_d  = duty_q;
        state_d = state_q;

        if (period_tick) begin
            tgt_d  = tgt_new;
            mode_d = mode;
            div_d  = step_ok ? rate_reload(rate) : div_q - 1'b1;

            case (mode)
                MODE_DIRECT: begin
                    duty_d  = tgt_new;
                    state_d = IDLE;
                end
                MODE_RAMP: begin
                    if (step_ok && (duty_q < tgt_new)) begin
                        duty_d = up_lim;
                    end else if (step_ok && (duty_q > tgt_new)) begin
                        duty_d = dn_lim;
                    end
                    if (duty_d < tgt_new) begin
                        state_d = UP;
                    end else if (duty_d > tgt_new) begin
                        state_d = DOWN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MODE_BREATHE: begin
                    if (!step_ok) begin
                        state_d = (br_go_up && (duty_q <= tgt_new)) ? BR_UP : BR_DN;
                    end else if (br_go_up && (duty_q < tgt_new)) begin
                        duty_d  = up_lim;
                        state_d = (up_lim == tgt_new) ? BR_DN : BR_UP;
                    end else begin
                        // Also covers a target lowered under duty: descend, never jump.
                        duty_d  = dn_floor;
                        state_d = (dn_floor == '0) ? BR_UP : BR_DN;
                    end
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q   <= '0;
            duty_q  <= '0;
            mode_q  <= MODE_DIRECT;
            div_q   <= '0;
            state_q <= IDLE;
        end else begin
            tgt_q   <= tgt_d;
            duty_q  <= duty_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            state_q <= state_d;
        end
    end

    assign duty_o    = duty_q;
    assign busy      = state_moving(state_q);
    assign at_target = (duty_q == tgt_q);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: two instances (STEP=1 and STEP=4) share stimulus and
// are checked every cycle against a per-period arithmetic model plus literal values.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] target = 6'd0;
    logic [1:0] mode = 2'd0;
    logic [1:0] rate = 2'd0;

    logic [5:0] duty_a, duty_b;
    logic       tick_a, tick_b, busy_a, busy_b, at_a, at_b;

    int checks = 0;
    int errors = 0;

    pwm_duty_ramp dut_a (
        .clk(clk), .rst(rst), .target(target), .mode(mode), .rate(rate),
        .duty_o(duty_a), .period_tick(tick_a), .busy(busy_a), .at_target(at_a)
    );

    pwm_duty_ramp #(.DUTY_W(6), .PERIOD(32), .DUTY_MAX(32), .STEP(4)) dut_b (
        .clk(clk), .rst(rst), .target(target), .mode(mode), .rate(rate),
        .duty_o(duty_b), .period_tick(tick_b), .busy(busy_b), .at_target(at_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_step [2] = '{1, 4};
    int m_duty [2];
    int m_tgt  [2];
    int m_div  [2];
    int m_dir  [2];
    int m_prev [2];
    int m_busy [2];
    int m_pcnt = 0;
    bit m_valid = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_duty[k] = 0; m_tgt[k] = 0; m_div[k] = 0;
            m_dir[k] = 0; m_prev[k] = 0; m_busy[k] = 0;
        end
        m_pcnt = 0;
    endtask

    task automatic model_tick(input int k);
        int t;
        bit allowed;
        t = (int'(target) > 32) ? 32 : int'(target);
        allowed = (m_div[k] == 0);
        m_div[k] = allowed ? ((1 << rate) - 1) : (m_div[k] - 1);
        case (mode)
            2'd0: begin
                m_duty[k] = t;
                m_busy[k] = 0;
            end
            2'd1: begin
                if (allowed && m_duty[k] < t)
                    m_duty[k] = (m_duty[k] + m_step[k] > t) ? t : m_duty[k] + m_step[k];
                else if (allowed && m_duty[k] > t)
                    m_duty[k] = (m_duty[k] - m_step[k] < t) ? t : m_duty[k] - m_step[k];
                m_busy[k] = (m_duty[k] != t);
            end
            2'd2: begin
                if (m_prev[k] != 2) m_dir[k] = (m_duty[k] > t) ? -1 : 1;
                if (allowed) begin
                    if (m_dir[k] > 0 && m_duty[k] < t) begin
                        m_duty[k] = (m_duty[k] + m_step[k] > t) ? t : m_duty[k] + m_step[k];
                        m_dir[k] = (m_duty[k] == t) ? -1 : 1;
                    end else begin
                        m_duty[k] = (m_duty[k] - m_step[k] < 0) ? 0 : m_duty[k] - m_step[k];
                        m_dir[k] = (m_duty[k] == 0) ? 1 : -1;
                    end
                end
                m_busy[k] = 1;
            end
            default: m_busy[k] = 0;
        endcase
        m_prev[k] = int'(mode);
        m_tgt[k] = t;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            model_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_pcnt == 31) begin
                model_tick(0);
                model_tick(1);
            end
            m_pcnt = (m_pcnt == 31) ? 0 : m_pcnt + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                int dv; int bv; int av; int tv;
                dv = (k == 0) ? int'(duty_a) : int'(duty_b);
                bv = (k == 0) ? int'(busy_a) : int'(busy_b);
                av = (k == 0) ? int'(at_a)   : int'(at_b);
                tv = (k == 0) ? int'(tick_a) : int'(tick_b);
                checks++;
                if (dv != m_duty[k] || bv != m_busy[k] || av != int'(m_duty[k] == m_tgt[k]) ||
                    tv != int'(m_pcnt == 31)) begin
                    errors++;
                    $display("FAIL model_cmp[%0d] t=%0t got duty=%0d busy=%0d at=%0d tick=%0d want duty=%0d busy=%0d at=%0d tick=%0d",
                             k, $time, dv, bv, av, tv, m_duty[k], m_busy[k],
                             int'(m_duty[k] == m_tgt[k]), int'(m_pcnt == 31));
                end
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Waits for the next period tick, then returns just after the updating edge.
    task automatic next_period();
        int n;
        n = 0;
        @(negedge clk);
        while (!tick_a && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!tick_a) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout got no tick within %0d cycles want tick", n);
        end
        @(posedge clk);
        #1;
        $display("period: mode=%0d target=%0d rate=%0d -> duty_a=%0d duty_b=%0d busy_a=%0d at_a=%0d",
                 mode, target, rate, duty_a, duty_b, busy_a, at_a);
    endtask

    int exp_br [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    initial begin
        int n;
        // Reset, with direct mode target=20 queued for the first tick
        rst = 1'b1; target = 6'd20; mode = 2'd0; rate = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_duty", int'(duty_a), 0);
        check("reset_busy", int'(busy_a), 0);
        check("reset_at_target", int'(at_a), 1);
        n = 1;
        while (!tick_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("first_tick_clock", n, 32);

        // Direct
        @(posedge clk); #1;
        check("direct_duty", int'(duty_a), 20);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            check("direct_stable", int'(duty_a), 20);
        end

        // Ramp up from 0, STEP=1
        target = 6'd0; mode = 2'd0;
        next_period();
        target = 6'd5; mode = 2'd1;
        for (int i = 1; i <= 5; i++) begin
            next_period();
            check("ramp_up_duty", int'(duty_a), i);
            if (i == 4) check("ramp_up_busy_mid", int'(busy_a), 1);
        end
        check("ramp_up_busy_end", int'(busy_a), 0);
        check("ramp_up_at_target", int'(at_a), 1);
        check("model_pin_ramp", m_duty[0], 5);

        // Ramp down with STEP=4 saturating at target
        target = 6'd10; mode = 2'd0;
        next_period();
        check("b_direct_10", int'(duty_b), 10);
        target = 6'd1; mode = 2'd1;
        next_period(); check("b_down_6", int'(duty_b), 6);
        next_period(); check("b_down_2", int'(duty_b), 2);
        next_period(); check("b_down_1", int'(duty_b), 1);
        next_period(); check("b_down_hold1", int'(duty_b), 1);
        check("a_down_step1", int'(duty_a), 6);

        // Clamp, then slow ramp at rate=2
        target = 6'd50; mode = 2'd0;
        next_period();
        check("clamp_duty", int'(duty_a), 32);
        check("clamp_at_target", int'(at_a), 1);
        target = 6'd28; mode = 2'd1; rate = 2'd2;
        next_period(); check("rate_t1", int'(duty_a), 31);
        next_period(); check("rate_t2", int'(duty_a), 31);
        next_period(); check("rate_t3", int'(duty_a), 31);
        next_period(); check("rate_t4", int'(duty_a), 31);
        next_period(); check("rate_t5", int'(duty_a), 30);
        check("rate_busy", int'(busy_a), 1);
        check("b_rate_done", int'(duty_b), 28);

        // Drain the divider back to zero, then breathe
        target = 6'd0; mode = 2'd0; rate = 2'd0;
        repeat (4) next_period();
        target = 6'd3; mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            next_period();
            check("breathe_duty", int'(duty_a), exp_br[i]);
            check("breathe_busy", int'(busy_a), 1);
        end
        check("model_pin_breathe", m_duty[0], 2);

        // Reset mid-breathe
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_duty", int'(duty_a), 0);
        check("rst_mid_busy", int'(busy_a), 0);
        check("rst_mid_at", int'(at_a), 1);
        @(negedge clk);
        rst = 1'b0;

        // Hold freezes duty while the target moves away
        target = 6'd7; mode = 2'd0;
        next_period();
        check("hold_pre", int'(duty_a), 7);
        target = 6'd20; mode = 2'd3;
        next_period();
        check("hold_duty", int'(duty_a), 7);
        check("hold_busy", int'(busy_a), 0);
        check("hold_at_target", int'(at_a), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
